// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the memory-access pipeline stage: FSM state encoding,
// the word-alignment mask, the wait-counter width and default parameter values.
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,   // no request outstanding
      ST_BUSY = 1'b1    // dmem_req high, waiting for dmem_ready
   } state_t;

   // Low address bits a legal load/store must carry (word aligned).
   localparam logic [1:0] ALIGN_MASK = 2'b00;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_WAIT_MAX = 15;
   localparam int unsigned CNT_W        = 8;

endpackage

// File: rtl/mem_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// 8-bit wait-cycle counter with synchronous clear and count enable. terminal is
// high while the count equals WAIT_MAX-1, i.e. in the last allowed wait cycle.
// Ports:
//   clock    in  rising-edge clock
//   reset    in  asynchronous, active-high; clears the count
//   clear    in  load zero on the next edge (has priority over enable)
//   enable   in  increment on the next edge
//   terminal out count == WAIT_MAX-1
// -----------------------------------------------------------------------------
module mem_wait_counter
   import mem_access_stage_pkg::*;
#(
   parameter int unsigned WAIT_MAX = DEF_WAIT_MAX
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(WAIT_MAX - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // NOTE: every always_comb output gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge value of its inputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign terminal = (count_q == TERM_VAL);

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access pipeline stage behind the execute-stage result register. Either
// passes alu_result through to write-back, or uses it as the address of a single
// load/store on a req/ready data-memory port, stalling upstream while the access
// is outstanding. Illegal (read+write), misaligned and timed-out accesses return
// a write-back pulse with mem_fault set and zero data.
// Ports:
//   clock, reset                     clock; async active-high reset
//   alu_result, store_data           address / pass-through value, store data
//   mem_read, mem_write, in_valid    instruction qualifiers
//   stall                            combinational hold request to upstream
//   dmem_req/we/addr/wdata           registered memory request
//   dmem_rdata, dmem_ready           memory response
//   wb_data, wb_valid, mem_fault     registered write-back result
// -----------------------------------------------------------------------------
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned WAIT_MAX = DEF_WAIT_MAX
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              in_valid,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_valid,
   output logic              mem_fault
);

   state_t            state_q, state_d;
   logic              dmem_req_q, dmem_req_d;
   logic              dmem_we_q, dmem_we_d;
   logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
   logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              wb_valid_q, wb_valid_d;
   logic              mem_fault_q, mem_fault_d;

   logic is_mem_op;
   logic accept;
   logic wait_term;

   assign is_mem_op = mem_read | mem_write;
   // Exactly one of read/write, and a word-aligned address.
   assign accept    = in_valid && (mem_read ^ mem_write) &&
                      (alu_result[1:0] == ALIGN_MASK);

   mem_wait_counter #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_counter (
      .clock    (clock),
      .reset    (reset),
      .clear    (state_q == ST_IDLE),
      .enable   ((state_q == ST_BUSY) && !dmem_ready),
      .terminal (wait_term)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A ready in the terminal wait cycle completes normally;
   // the timeout only decides the outcome when ready is low.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_BUSY;
         ST_BUSY: if (dmem_ready || wait_term) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: stall plus next values of the registered outputs.
   always_comb begin
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      wb_data_d    = wb_data_q;
      wb_valid_d   = 1'b0;
      mem_fault_d  = 1'b0;
      // Reset abandons any access at once, so stall is forced low with it even
      // though upstream may still be holding an acceptable instruction.
      stall        = !reset &&
                     (((state_q == ST_IDLE) && accept) ||
                      ((state_q == ST_BUSY) && !dmem_ready));

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               dmem_req_d   = 1'b1;
               dmem_we_d    = mem_write;
               dmem_addr_d  = alu_result;
               dmem_wdata_d = mem_write ? store_data : '0;
            end else if (in_valid && is_mem_op) begin
               // Illegal read+write or misaligned address: fault, no request.
               wb_valid_d  = 1'b1;
               mem_fault_d = 1'b1;
               wb_data_d   = '0;
            end else if (in_valid) begin
               wb_valid_d = 1'b1;
               wb_data_d  = alu_result;
            end
         end
         ST_BUSY: begin
            if (dmem_ready) begin
               dmem_req_d = 1'b0;
               wb_valid_d = 1'b1;
               wb_data_d  = dmem_we_q ? dmem_addr_q : dmem_rdata;
            end else if (wait_term) begin
               dmem_req_d  = 1'b0;
               wb_valid_d  = 1'b1;
               mem_fault_d = 1'b1;
               wb_data_d   = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         wb_data_q    <= '0;
         wb_valid_q   <= 1'b0;
         mem_fault_q  <= 1'b0;
      end else begin
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         wb_data_q    <= wb_data_d;
         wb_valid_q   <= wb_valid_d;
         mem_fault_q  <= mem_fault_d;
      end
   end

   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign wb_data    = wb_data_q;
   assign wb_valid   = wb_valid_q;
   assign mem_fault  = mem_fault_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access pipeline stage directly downstream of the execute-stage result register. Takes the registered ALU result as a load/store address, or as a pass-through value, and drives a single-port data-memory request/ready handshake. Stalls the upstream stages while an access is outstanding. Produces one registered write-back result per instruction.

Parameters:
DATA_W, 32, width of the ALU result, store data and load data
WAIT_MAX, 15, maximum number of BUSY cycles with dmem_ready low before a timeout fault; legal range 1..255

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
alu_result  input  DATA_W  registered ALU output; the address for load/store, otherwise the pass-through value
store_data  input  DATA_W  write data for a store
mem_read  input  1  instruction is a load
mem_write  input  1  instruction is a store
in_valid  input  1  inputs hold a valid instruction this cycle
stall  output  1  combinational; upstream must hold its inputs while high
dmem_req  output  1  memory request, registered
dmem_we  output  1  1 = write, 0 = read, registered
dmem_addr  output  DATA_W  latched address
dmem_wdata  output  DATA_W  latched store data
dmem_rdata  input  DATA_W  load data, valid when dmem_ready is high
dmem_ready  input  1  memory completes the request this cycle
wb_data  output  DATA_W  write-back value, registered
wb_valid  output  1  one-cycle pulse: wb_data is valid
mem_fault  output  1  qualifies wb_valid: the access faulted

Behaviour:
- Reset is asynchronous. It forces state IDLE, the wait counter to 0, and dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_data, wb_valid and mem_fault to 0. Reset asserted mid-access abandons the request immediately: dmem_req goes low without waiting for dmem_ready.
- States:
  - IDLE: no request outstanding.
  - BUSY: dmem_req is high, waiting for dmem_ready.
- IDLE, in_valid=0: no state change; wb_valid is 0 on the next cycle.
- IDLE, in_valid=1, mem_read=0, mem_write=0 (pass-through): next edge sets wb_data to alu_result, wb_valid to 1, mem_fault to 0. Stall stays low.
- IDLE, in_valid=1, both mem_read and mem_write high: illegal. Next edge gives wb_valid=1, mem_fault=1, wb_data=0. No request is issued and stall stays low.
- IDLE, in_valid=1, exactly one of mem_read/mem_write, alu_result[1:0] not 00: misaligned. Same response as illegal: fault pulse, no request.
- IDLE, legal aligned access (accept):
  - stall is high in the accept cycle.
  - Next edge latches dmem_addr=alu_result, dmem_wdata=store_data (0 for a load), dmem_we=mem_write, dmem_req=1, counter=0, and enters BUSY.
- BUSY, dmem_ready=1 (completion):
  - stall is low in this cycle, so upstream advances on the same edge.
  - Next edge: dmem_req=0, wb_valid=1, mem_fault=0, returns to IDLE.
  - wb_data = dmem_rdata for a load; wb_data = dmem_addr for a store.
- BUSY, dmem_ready=0:
  - stall is high; the counter increments.
  - If the counter equals WAIT_MAX-1 in this cycle, the next edge aborts the access: dmem_req=0, wb_valid=1, mem_fault=1, wb_data=0, returns to IDLE.
  - A dmem_ready arriving in that same cycle wins: normal completion, no fault.
- Inputs presented while in BUSY are ignored; upstream holds them because stall is high.
- dmem_ready while IDLE is ignored.
- stall = (IDLE and accept) or (BUSY and not dmem_ready).
- Latency:
  - Pass-through and fault results: 1 cycle after the input cycle.
  - Zero-wait memory access: accept at edge k, BUSY during cycle k..k+1, wb_valid high in the cycle after edge k+1 (2-cycle latency).
- Back-to-back: a new access may be accepted in the cycle immediately after a completion.
- wb_valid and mem_fault are each high for at most one cycle per instruction.

Decomposition:
- Shared package holds the state encoding (ST_IDLE, ST_BUSY), the alignment mask constant (2'b00), and the default DATA_W and WAIT_MAX values.
- One sub-module, mem_wait_counter: 8-bit counter with clear, enable and a terminal flag at WAIT_MAX-1. Async reset on the same reset port.

Test Plan:
- Pass-through: in_valid=1, mem_read=mem_write=0, alu_result=0x0000_1234 -> one cycle later wb_valid=1, wb_data=0x0000_1234, mem_fault=0, stall never high.
- Zero-wait load: alu_result=0x100, mem_read=1, dmem_ready=1 in first BUSY cycle, dmem_rdata=0xDEAD_BEEF -> dmem_req high exactly 1 cycle with dmem_addr=0x100, dmem_we=0; wb_data=0xDEAD_BEEF, wb_valid=1 two cycles after input.
- Store with 3 wait cycles: alu_result=0x200, store_data=0xCAFE_0001 -> dmem_we=1, dmem_wdata=0xCAFE_0001 held 4 cycles; stall high through the wait cycles; wb_data=0x200, mem_fault=0.
- Misaligned / illegal: alu_result=0x203 with mem_read=1, then mem_read=mem_write=1 -> each gives wb_valid=1, mem_fault=1, wb_data=0, dmem_req stays 0.
- Timeout: WAIT_MAX=15, load, dmem_ready held 0 -> dmem_req high 15 cycles, then wb_valid=1, mem_fault=1, stall low; repeat with dmem_ready=1 on the 15th cycle -> normal completion, no fault.
- Async reset mid-BUSY: assert reset between clock edges -> dmem_req, stall and wb_valid drop immediately; after release, next access completes normally.
